// File: rtl/pc_unit.sv
// Program counter with boot sequencing, fixed-priority next-PC selection,
// alignment checking and a circular return-address stack.
module pc_unit #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             startin_n,
   input  logic             stall,
   input  logic             exc,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_offset,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             jr,
   input  logic [WIDTH-1:0] jr_target,
   input  logic             call,
   input  logic             ret,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             misalign_err,
   output logic             state_dbg
);

   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CW = $clog2(RAS_DEPTH + 1);

   typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

   state_t           state;
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]    top_ptr;
   logic [PW-1:0]    top_ptr_next;
   logic [PW-1:0]    ptr_inc;
   logic [PW-1:0]    ptr_dec;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             ras_wr;
   logic             ras_active;
   logic             stack_empty;

   logic [WIDTH-1:0] br_target;
   logic [WIDTH-1:0] ret_target;
   logic [WIDTH-1:0] redirect;
   logic [WIDTH-1:0] pc_next;
   logic             redirect_en;
   logic             misalign;

   assign pc_plus4    = out + WIDTH'(4);
   assign br_target   = pc_plus4 + (br_offset << 2);
   assign stack_empty = (count == '0);
   assign ret_target  = stack_empty ? jr_target : ras_mem[top_ptr];
   assign state_dbg   = (state == RUN);

   // Stack traffic only happens on a cycle that actually advances the PC.
   assign ras_active = (state == RUN) && !exc && !stall;

   assign ptr_inc = (top_ptr == PW'(RAS_DEPTH - 1)) ? '0 : top_ptr + PW'(1);
   assign ptr_dec = (top_ptr == '0) ? PW'(RAS_DEPTH - 1) : top_ptr - PW'(1);

   always_comb begin
      redirect_en = 1'b0;
      redirect    = pc_plus4;
      if (ret) begin
         redirect_en = 1'b1;
         redirect    = ret_target;
      end else if (jr) begin
         redirect_en = 1'b1;
         redirect    = jr_target;
      end else if (jump) begin
         redirect_en = 1'b1;
         redirect    = jump_target;
      end else if (br_taken) begin
         redirect_en = 1'b1;
         redirect    = br_target;
      end
      misalign = redirect_en && (redirect[1:0] != 2'b00);

      if (exc)              pc_next = EXC_VECTOR;
      else if (stall)       pc_next = out;
      else if (misalign)    pc_next = EXC_VECTOR;
      else if (redirect_en) pc_next = redirect;
      else                  pc_next = pc_plus4;
   end

   // Simultaneous ret+call swaps the top in place; on an empty stack the pop
   // is a no-op so it degenerates to a plain push.
   always_comb begin
      ras_wr       = 1'b0;
      wr_ptr       = top_ptr;
      top_ptr_next = top_ptr;
      count_next   = count;
      if (ras_active) begin
         if (ret && call && !stack_empty) begin
            ras_wr = 1'b1;
            wr_ptr = top_ptr;
         end else if (call && (ret || jr || jump)) begin
            ras_wr       = 1'b1;
            wr_ptr       = ptr_inc;
            top_ptr_next = ptr_inc;
            if (count != CW'(RAS_DEPTH)) count_next = count + CW'(1);
         end else if (ret && !stack_empty) begin
            top_ptr_next = ptr_dec;
            count_next   = count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge startin_n) begin
      if (!startin_n) begin
         state        <= BOOT;
         out          <= RESET_VECTOR;
         count        <= '0;
         top_ptr      <= PW'(RAS_DEPTH - 1);
         ras_empty    <= 1'b1;
         ras_full     <= 1'b0;
         misalign_err <= 1'b0;
      end else if (state == BOOT) begin
         state        <= RUN;
         out          <= RESET_VECTOR;
         misalign_err <= 1'b0;
      end else begin
         out          <= pc_next;
         count        <= count_next;
         top_ptr      <= top_ptr_next;
         ras_empty    <= (count_next == '0);
         ras_full     <= (count_next == CW'(RAS_DEPTH));
         misalign_err <= misalign && !exc && !stall;
      end
   end

   // Entries beyond count are don't-care, so the storage needs no reset.
   always_ff @(posedge clk) begin
      if (ras_wr) ras_mem[wr_ptr] <= pc_plus4;
   end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: reset/boot sequence, directed vector table, reset pulse
// corner case, then random traffic against a queue-based reference model.
module tb_pc_unit;
   localparam int W = 32;
   localparam int DEPTH = 4;
   localparam logic [W-1:0] RST_V = 32'h0000_0000;
   localparam logic [W-1:0] EXC_V = 32'h0000_0180;

   // control word order: {stall, exc, br_taken, jump, jr, call, ret}
   localparam logic [6:0] NO = 7'h00, ST = 7'h40, EX = 7'h20, BR = 7'h10,
                          JP = 7'h08, JR = 7'h04, CL = 7'h02, RT = 7'h01;
   // flag word order: {ras_empty, ras_full, misalign_err}
   localparam logic [2:0] FN = 3'b000, FE = 3'b100, FF = 3'b010, FM = 3'b001;

   typedef struct {
      logic [6:0]   ctl;
      logic [W-1:0] off;
      logic [W-1:0] jt;
      logic [W-1:0] jrt;
      logic [W-1:0] e_out;
      logic [2:0]   e_flg;
   } vec_t;

   logic         clk = 1'b0;
   logic         startin_n = 1'b1;
   logic         stall = 1'b0, exc = 1'b0, br_taken = 1'b0, jump = 1'b0;
   logic         jr = 1'b0, call = 1'b0, ret = 1'b0;
   logic [W-1:0] br_offset = '0, jump_target = '0, jr_target = '0;
   logic [W-1:0] out, pc_plus4;
   logic         ras_empty, ras_full, misalign_err, state_dbg;

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [W-1:0] exp_q[$];
   vec_t         tbl[$];

   always #5 clk = ~clk;

   pc_unit #(
      .WIDTH(W), .RESET_VECTOR(RST_V), .EXC_VECTOR(EXC_V), .RAS_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .startin_n(startin_n), .stall(stall), .exc(exc),
      .br_taken(br_taken), .br_offset(br_offset), .jump(jump),
      .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
      .call(call), .ret(ret), .out(out), .pc_plus4(pc_plus4),
      .ras_empty(ras_empty), .ras_full(ras_full),
      .misalign_err(misalign_err), .state_dbg(state_dbg)
   );

   task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic apply(input logic [6:0] ctl, input logic [W-1:0] off,
                        input logic [W-1:0] jt, input logic [W-1:0] jrt);
      {stall, exc, br_taken, jump, jr, call, ret} = ctl;
      br_offset   = off;
      jump_target = jt;
      jr_target   = jrt;
   endtask

   function automatic vec_t mk(input logic [6:0] ctl, input logic [W-1:0] off,
                               input logic [W-1:0] jt, input logic [W-1:0] jrt,
                               input logic [W-1:0] e_out, input logic [2:0] e_flg);
      vec_t v;
      v.ctl = ctl; v.off = off; v.jt = jt; v.jrt = jrt;
      v.e_out = e_out; v.e_flg = e_flg;
      return v;
   endfunction

   initial begin
      logic [W-1:0] mpc, npc, p4, tgt;
      logic [W-1:0] ras_q[$];
      logic         have, mis_e;
      logic [6:0]   ctl;
      logic [W-1:0] rjt, rjrt, roff;

      // Directed vectors, applied from out=0x8 with an empty stack.
      tbl.push_back(mk(JP,      0, 32'h100, 0, 32'h100, FE));
      tbl.push_back(mk(BR,      32'hFFFF_FFFE, 0, 0, 32'h0FC, FE));
      tbl.push_back(mk(JP,      0, 32'h100, 0, 32'h100, FE));
      tbl.push_back(mk(ST|JP,   0, 32'h300, 0, 32'h100, FE));
      tbl.push_back(mk(JP,      0, 32'h040, 0, 32'h040, FE));
      tbl.push_back(mk(JP|CL,   0, 32'h200, 0, 32'h200, FN));
      tbl.push_back(mk(RT,      0, 0, 32'h900, 32'h044, FE));
      tbl.push_back(mk(JP,      0, 32'h010, 0, 32'h010, FE));
      tbl.push_back(mk(JP|CL,   0, 32'h020, 0, 32'h020, FN));
      tbl.push_back(mk(JP|CL,   0, 32'h030, 0, 32'h030, FN));
      tbl.push_back(mk(JP|CL,   0, 32'h040, 0, 32'h040, FN));
      tbl.push_back(mk(JR|CL,   0, 0, 32'h050, 32'h050, FF));
      tbl.push_back(mk(JP|CL,   0, 32'h1000, 0, 32'h1000, FF));
      tbl.push_back(mk(RT,      0, 0, 32'h900, 32'h054, FN));
      tbl.push_back(mk(RT,      0, 0, 32'h900, 32'h044, FN));
      tbl.push_back(mk(RT,      0, 0, 32'h900, 32'h034, FN));
      tbl.push_back(mk(RT,      0, 0, 32'h900, 32'h024, FE));
      tbl.push_back(mk(RT,      0, 0, 32'h600, 32'h600, FE));
      tbl.push_back(mk(JP,      0, 32'h202, 0, EXC_V, FE|FM));
      tbl.push_back(mk(NO,      0, 0, 0, 32'h184, FE));
      tbl.push_back(mk(EX|ST,   0, 0, 0, EXC_V, FE));
      tbl.push_back(mk(ST,      0, 0, 0, EXC_V, FE));
      tbl.push_back(mk(JP,      0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, FE));
      tbl.push_back(mk(NO,      0, 0, 0, 32'h0, FE));
      tbl.push_back(mk(JP|CL,   0, 32'h700, 0, 32'h700, FN));
      tbl.push_back(mk(EX|RT|CL,0, 0, 32'h900, EXC_V, FN));
      tbl.push_back(mk(ST|RT,   0, 0, 32'h900, EXC_V, FN));
      tbl.push_back(mk(RT,      0, 0, 32'h900, 32'h004, FE));
      tbl.push_back(mk(JP|CL,   0, 32'h800, 0, 32'h800, FN));
      tbl.push_back(mk(RT|CL,   0, 0, 32'h900, 32'h008, FN));
      tbl.push_back(mk(RT,      0, 0, 32'h900, 32'h804, FE));
      tbl.push_back(mk(JR,      0, 0, 32'h301, EXC_V, FE|FM));
      tbl.push_back(mk(BR,      32'h3, 0, 0, 32'h190, FE));
      tbl.push_back(mk(EX|JP|CL,0, 32'h400, 0, EXC_V, FE));
      tbl.push_back(mk(RT,      0, 0, 32'h1234, 32'h1234, FE));

      // Reset and boot.
      #1 startin_n = 1'b0;
      apply(NO, 0, 0, 0);
      repeat (2) @(negedge clk);
      check_w("reset out", out, RST_V);
      check_b("reset ras_empty", ras_empty, 1'b1);
      check_b("reset ras_full", ras_full, 1'b0);
      check_b("reset misalign_err", misalign_err, 1'b0);
      check_b("reset state", state_dbg, 1'b0);
      startin_n = 1'b1;
      #1 check_w("release out0", out, 32'h0);
      @(negedge clk);
      check_w("boot out1", out, 32'h0);
      check_b("boot state", state_dbg, 1'b1);
      @(negedge clk);
      check_w("run out2", out, 32'h4);
      @(negedge clk);
      check_w("run out3", out, 32'h8);

      foreach (tbl[i]) begin
         apply(tbl[i].ctl, tbl[i].off, tbl[i].jt, tbl[i].jrt);
         @(negedge clk);
         check_w($sformatf("vec%0d out", i), out, tbl[i].e_out);
         check_b($sformatf("vec%0d ras_empty", i), ras_empty, tbl[i].e_flg[2]);
         check_b($sformatf("vec%0d ras_full", i), ras_full, tbl[i].e_flg[1]);
         check_b($sformatf("vec%0d misalign_err", i), misalign_err, tbl[i].e_flg[0]);
      end

      // Fill the stack, sit at 0x80, then pulse reset between edges.
      apply(JP|CL, 0, 32'h80, 0);
      repeat (4) @(negedge clk);
      apply(NO, 0, 0, 0);
      check_w("prepulse out", out, 32'h80);
      check_b("prepulse ras_full", ras_full, 1'b1);
      #2 startin_n = 1'b0;
      #1;
      check_w("pulse out", out, RST_V);
      check_b("pulse ras_empty", ras_empty, 1'b1);
      check_b("pulse ras_full", ras_full, 1'b0);
      check_b("pulse state", state_dbg, 1'b0);
      #1 startin_n = 1'b1;
      @(negedge clk);
      check_w("postpulse boot out", out, 32'h0);
      @(negedge clk);
      check_w("postpulse run out", out, 32'h4);
      apply(RT, 0, 0, 32'h500);
      @(negedge clk);
      check_w("postpulse ret out", out, 32'h500);
      check_b("postpulse ras_empty", ras_empty, 1'b1);

      // Random traffic against the reference model.
      mpc = 32'h500;
      for (int i = 0; i < 400; i++) begin
         ctl[6] = ($urandom_range(0, 7) == 0);
         ctl[5] = ($urandom_range(0, 15) == 0);
         ctl[4] = ($urandom_range(0, 3) == 0);
         ctl[3] = ($urandom_range(0, 5) == 0);
         ctl[2] = ($urandom_range(0, 5) == 0);
         ctl[1] = ($urandom_range(0, 2) == 0);
         ctl[0] = ($urandom_range(0, 4) == 0);
         rjt  = $urandom & ~32'h3;
         rjrt = $urandom & ~32'h3;
         if ($urandom_range(0, 9) == 0) rjt[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) rjrt[1:0] = 2'($urandom_range(1, 3));
         roff = 32'($urandom_range(0, 64)) - 32'd32;
         apply(ctl, roff, rjt, rjrt);

         mis_e = 1'b0;
         if (exc) npc = EXC_V;
         else if (stall) npc = mpc;
         else begin
            p4   = mpc + 32'd4;
            have = 1'b1;
            tgt  = p4;
            if (ret) tgt = (ras_q.size() > 0) ? ras_q[ras_q.size() - 1] : jr_target;
            else if (jr) tgt = jr_target;
            else if (jump) tgt = jump_target;
            else if (br_taken) tgt = p4 + br_offset * 32'd4;
            else have = 1'b0;
            if (have && tgt[1:0] != 2'b00) begin
               npc = EXC_V;
               mis_e = 1'b1;
            end else npc = tgt;
            if (ret && call) begin
               if (ras_q.size() > 0) ras_q[ras_q.size() - 1] = p4;
               else ras_q.push_back(p4);
            end else if (ret) begin
               if (ras_q.size() > 0) void'(ras_q.pop_back());
            end else if (call && (jr || jump)) begin
               if (ras_q.size() == DEPTH) void'(ras_q.pop_front());
               ras_q.push_back(p4);
            end
         end
         mpc = npc;
         exp_q.push_back(npc);

         @(negedge clk);
         npc = exp_q.pop_front();
         check_w($sformatf("rnd%0d out", i), out, npc);
         check_w($sformatf("rnd%0d pc_plus4", i), pc_plus4, npc + 32'd4);
         check_b($sformatf("rnd%0d ras_empty", i), ras_empty, ras_q.size() == 0);
         check_b($sformatf("rnd%0d ras_full", i), ras_full, ras_q.size() == DEPTH);
         check_b($sformatf("rnd%0d misalign_err", i), misalign_err, mis_e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: PC and target width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value while in reset and in BOOT.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_0180: PC loaded on exception or misaligned redirect.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, allowed range 2..16: return-address stack entries.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-006 SHALL have port startin_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port stall, input, 1 bit: hold PC.
REQ-008 SHALL have port exc, input, 1 bit: exception request.
REQ-009 SHALL have port br_taken, input, 1 bit, and port br_offset, input, WIDTH bits: signed word offset.
REQ-010 SHALL have port jump, input, 1 bit, and port jump_target, input, WIDTH bits: absolute target.
REQ-011 SHALL have port jr, input, 1 bit, and port jr_target, input, WIDTH bits: register target.
REQ-012 SHALL have port call, input, 1 bit: qualifies a jump/jr as a call.
REQ-013 SHALL have port ret, input, 1 bit: return; pops the stack.
REQ-014 SHALL have port out, output, WIDTH bits: current PC, registered.
REQ-015 SHALL have port pc_plus4, output, WIDTH bits: out+4, combinational.
REQ-016 SHALL have ports ras_empty and ras_full, outputs, 1 bit each: stack status, registered.
REQ-017 SHALL have port misalign_err, output, 1 bit: one-cycle pulse, registered.

Function
REQ-018 SHALL implement two states: BOOT and RUN; reset enters BOOT; BOOT→RUN after exactly one clock with startin_n high; in BOOT all requests are ignored and out holds RESET_VECTOR.
REQ-019 In RUN, the next PC SHALL be selected by fixed priority: exc→EXC_VECTOR; stall→out; ret→RAS top (jr_target if ras_empty); jr→jr_target; jump→jump_target; br_taken→out+4+(br_offset<<2); otherwise out+4.
REQ-020 All additions SHALL be modulo 2^WIDTH; out = all-ones−3 advancing SHALL wrap to 0.
REQ-021 If the selected redirect target (ret/jr/jump/branch) has bits[1:0]≠0, next PC SHALL be EXC_VECTOR and misalign_err SHALL be 1 for the following cycle only.
REQ-022 When call is high with jump or jr (and no higher-priority exc/stall), pc_plus4 SHALL be pushed onto the RAS.
REQ-023 A push when full SHALL overwrite the oldest entry (circular); ras_full stays 1 and the count is unchanged.
REQ-024 A pop when empty SHALL leave the stack unchanged; ret then uses jr_target.
REQ-025 When ret and call are both active, the top entry SHALL be replaced by pc_plus4, the count SHALL be unchanged, and next PC SHALL be the old top.
REQ-026 Stall or exc SHALL suppress all RAS pushes/pops in that cycle; exc SHALL NOT clear the RAS.
REQ-027 ras_empty SHALL equal (count==0) and ras_full SHALL equal (count==RAS_DEPTH), both updated with the same edge as the stack.

Reset
REQ-028 While startin_n=0, out SHALL be RESET_VECTOR, the RAS count SHALL be 0, ras_empty SHALL be 1, ras_full SHALL be 0, misalign_err SHALL be 0, and state SHALL be BOOT, taking effect immediately without a clock edge.
REQ-029 Reset asserted mid-operation (e.g. during a stall or a full RAS) SHALL discard all state; RAS contents SHALL be treated as invalid.

Verification
REQ-030 Release reset, no requests, 4 clocks → out = 0, 0, 4, 8.
REQ-031 At out=0x100, br_taken=1, br_offset=−2 → next out=0xFC; at out=0x100, stall=1 and jump=1 → out remains 0x100.
REQ-032 At out=0x40, jump=1, call=1, jump_target=0x200; then ret=1 at 0x200 → out 0x200, then 0x44; ras_empty returns to 1.
REQ-033 Five calls with RAS_DEPTH=4 from PCs 0x10/0x20/0x30/0x40/0x50 → ras_full=1; four rets yield 0x54, 0x44, 0x34, 0x24; a fifth ret uses jr_target.
REQ-034 jump_target=0x202 → out=EXC_VECTOR next cycle and misalign_err high for exactly one cycle; exc together with stall → out=EXC_VECTOR.
REQ-035 startin_n pulsed low between clock edges while out=0x80 → out=0 immediately; the first post-release edge holds 0 (BOOT) and the next gives 4.
